fazyrv_cmp_seq: RTL and testbench

Chunk-serial magnitude comparator, the consuming end of the per-chunk compare path. It takes two XLEN-bit operands as a stream of CHUNKSIZE-bit chunks, least-significant chunk first. It accumulates a running less/equal/greater verdict and presents a registered three-way result with a done pulse. Used by branch (BLT/BGE/BLTU/BGEU/BEQ/BNE) and SLT/SLTU evaluation in the chunked datapath.

---
 rtl/fazyrv_cmp_seq.sv | 107 ++++++++++
 tb/tb_fazyrv_cmp_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fazyrv_cmp_seq.sv
// rtl/fazyrv_cmp_seq.sv - chunk-serial three-way magnitude comparator
module fazyrv_cmp_seq #(
  parameter int CHUNKSIZE = 2,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 vld_i,
  input  logic [CHUNKSIZE-1:0] a_i,
  input  logic [CHUNKSIZE-1:0] b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 lt_o,
  output logic                 eq_o,
  output logic                 gt_o
);

  localparam int N  = XLEN / CHUNKSIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]        LAST_IDX = CW'(N - 1);
  // Sign bit position inside a chunk; for 1-bit chunks this is the whole chunk.
  localparam logic [CHUNKSIZE-1:0] MSB_MASK = CHUNKSIZE'(1) << (CHUNKSIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 sgn;

  logic                 last_chunk;
  logic [CHUNKSIZE-1:0] flip;
  logic [CHUNKSIZE-1:0] a_adj;
  logic [CHUNKSIZE-1:0] b_adj;
  logic                 chunk_lt;
  logic                 chunk_gt;

  // Per-chunk compare; inverting the sign bit of the top chunk turns a
  // two's-complement compare into an unsigned one.
  always_comb begin
    last_chunk = (cnt == LAST_IDX);
    flip       = (last_chunk && sgn) ? MSB_MASK : '0;
    a_adj      = a_i ^ flip;
    b_adj      = b_i ^ flip;
    chunk_lt   = (a_adj < b_adj);
    chunk_gt   = (a_adj > b_adj);
  end

  // Sequencer and running verdict; later (more significant) chunks override.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      sgn   <= 1'b0;
      lt_o  <= 1'b0;
      eq_o  <= 1'b1;
      gt_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state <= S_RUN;
            sgn   <= signed_i;
            cnt   <= '0;
            lt_o  <= 1'b0;
            eq_o  <= 1'b1;
            gt_o  <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (vld_i) begin
            if (chunk_lt) begin
              lt_o <= 1'b1;
              eq_o <= 1'b0;
              gt_o <= 1'b0;
            end else if (chunk_gt) begin
              lt_o <= 1'b0;
              eq_o <= 1'b0;
              gt_o <= 1'b1;
            end
            cnt <= cnt + CW'(1);
            if (last_chunk) begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy_o = (state == S_RUN);
    done_o = (state == S_DONE);
  end

endmodule

// File: tb/tb_fazyrv_cmp_seq.sv
// tb/tb_fazyrv_cmp_seq.sv - directed vector bench for fazyrv_cmp_seq
module tb_fazyrv_cmp_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic       sgn_i;
  logic       vld;
  logic [7:0] ach;
  logic [7:0] bch;
  logic [3:0] busy_w, done_w, lt_w, eq_w, gt_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance g uses CHUNKSIZE = 1, 2, 4, 8 for g = 0..3.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fazyrv_cmp_seq #(.CHUNKSIZE(1 << g), .XLEN(32)) u_dut (
      .clk_i   (clk),
      .rst_in  (rst_n),
      .start_i (start_v[g]),
      .signed_i(sgn_i),
      .vld_i   (vld),
      .a_i     (ach[(1<<g)-1:0]),
      .b_i     (bch[(1<<g)-1:0]),
      .busy_o  (busy_w[g]),
      .done_o  (done_w[g]),
      .lt_o    (lt_w[g]),
      .eq_o    (eq_w[g]),
      .gt_o    (gt_w[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    bit          stall;
    logic        lt;
    logic        eq;
    logic        gt;
    string       name;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input bit st, input logic l, input logic e, input logic g,
                              input string nm);
    vec_t v;
    v.a = a; v.b = b; v.sgn = s; v.stall = st;
    v.lt = l; v.eq = e; v.gt = g; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts a compare on instance sel at the current negedge and feeds chunks
  // until done_o is seen. Returning on the DONE negedge lets the next call
  // restart back-to-back.
  task automatic run_cmp(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit stall, input int exp_cyc,
                         input logic elt, input logic eeq, input logic egt,
                         input string tag);
    int cs, n, idx, cyc;
    bit got, v;
    cs  = 1 << sel;
    n   = 32 / cs;
    idx = 0;
    cyc = 0;
    got = 0;
    start_v      = 4'b0000;
    start_v[sel] = 1'b1;
    sgn_i        = s;
    vld          = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_v = 4'b0000;
      sgn_i   = ~s;
      if (vld) idx++;
      vld = 1'b0;
      if (cyc == 1) chk({tag, " busy_after_start"}, int'(busy_w[sel]), 1);
      if (done_w[sel]) begin
        got = 1;
      end else if (busy_w[sel]) begin
        v   = stall ? bit'($urandom_range(0, 1)) : 1'b1;
        vld = v;
        if (v) begin
          ach = 8'(a >> (idx * cs));
          bch = 8'(b >> (idx * cs));
        end else begin
          ach = 8'($urandom);
          bch = 8'($urandom);
        end
      end
    end
    chk({tag, " done_seen"}, int'(got), 1);
    if (exp_cyc > 0) chk({tag, " start_to_done"}, cyc, exp_cyc);
    chk({tag, " accepted"}, idx, n);
    chk({tag, " lt"}, int'(lt_w[sel]), int'(elt));
    chk({tag, " eq"}, int'(eq_w[sel]), int'(eeq));
    chk({tag, " gt"}, int'(gt_w[sel]), int'(egt));
  endtask

  initial begin
    vecs[0] = mk(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0, 0, "u_1_vs_ffff");
    vecs[1] = mk(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1, "s_1_vs_m1");
    vecs[2] = mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 0, 0, "s_min_vs_max");
    vecs[3] = mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 0, 0, 1, "u_8000_vs_7fff");
    vecs[4] = mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 0, "u_equal");
    vecs[5] = mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1, 0, "s_equal");
    vecs[6] = mk(32'h1234_5679, 32'h1234_5678, 1'b0, 1'b0, 0, 0, 1, "lsb_diff");
    vecs[7] = mk(32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b1, 0, 0, 1, "stall_gt");
    vecs[8] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 0, 1, 0, "stall_zero");
    vecs[9] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 0, 1, "s_m1_vs_m2");

    rst_n   = 1'b0;
    start_v = 4'b0000;
    sgn_i   = 1'b0;
    vld     = 1'b0;
    ach     = 8'h00;
    bch     = 8'h00;

    #12;
    chk("reset busy", int'(busy_w[1]), 0);
    chk("reset done", int'(done_w[1]), 0);
    chk("reset eq",   int'(eq_w[1]), 1);
    chk("reset lt",   int'(lt_w[1]), 0);
    chk("reset gt",   int'(gt_w[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-run after 5 accepted chunks of 1 vs 0xFFFFFFFF (verdict is lt).
    @(negedge clk);
    start_v = 4'b0010;
    sgn_i   = 1'b0;
    @(negedge clk);
    start_v = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      vld = 1'b1;
      ach = 8'(32'h0000_0001 >> (2 * k));
      bch = 8'(32'hFFFF_FFFF >> (2 * k));
      @(negedge clk);
    end
    vld = 1'b0;
    chk("midrun busy", int'(busy_w[1]), 1);
    chk("midrun lt",   int'(lt_w[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst busy", int'(busy_w[1]), 0);
    chk("async_rst eq",   int'(eq_w[1]), 1);
    chk("async_rst lt",   int'(lt_w[1]), 0);
    chk("async_rst gt",   int'(gt_w[1]), 0);
    chk("async_rst done", int'(done_w[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // CHUNKSIZE=2 vector table, each run restarting from the previous DONE cycle.
    for (int i = 0; i < 10; i++) begin
      run_cmp(1, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].stall,
              vecs[i].stall ? 0 : 17, vecs[i].lt, vecs[i].eq, vecs[i].gt, vecs[i].name);
    end

    // done_o is a single pulse and the verdict holds through IDLE.
    @(negedge clk);
    chk("post_done done", int'(done_w[1]), 0);
    chk("post_done busy", int'(busy_w[1]), 0);
    @(negedge clk);
    @(negedge clk);
    chk("idle_hold gt", int'(gt_w[1]), 1);
    chk("idle_hold eq", int'(eq_w[1]), 0);
    chk("idle_hold lt", int'(lt_w[1]), 0);

    // Other chunk widths: signed then back-to-back unsigned.
    for (int s = 0; s < 4; s++) begin
      if (s != 1) begin
        run_cmp(s, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, (32 >> s) + 1,
                1, 0, 0, $sformatf("cs%0d_signed", 1 << s));
        run_cmp(s, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, (32 >> s) + 1,
                0, 0, 1, $sformatf("cs%0d_unsigned", 1 << s));
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
